pipe_stage_register: RTL

- Parametrised pipeline stage register with a valid/ready handshake, replacing the fixed 32-bit enable/clear stage registers between pipeline stages.
- Carries an arbitrary payload, for example {instr, pc_plus4} or wider execute/memory bundles.
- Contains a 2-entry skid buffer so that the upstream in_ready is a registered signal and never depends combinationally on out_ready.
- Supports flush (bubble insertion with a NOP/clear payload) and provides saturating stall and flush counters for performance debug.

---
 rtl/pipe_stage_register_if.sv | 12 +
 rtl/pipe_stage_register.sv | 99 +++++++++
 2 files changed

// File: rtl/pipe_stage_register_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid/data and the slave drives ready.
interface pipe_stage_register_if #(
  parameter int unsigned DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_register.sv
// Pipeline stage register with a 2-entry skid buffer; 1-cycle latency, full throughput.
// in_if.ready is registered (!skid_valid) and never depends on out_if.ready; flush drops all entries.
module pipe_stage_register #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] CLR_VALUE  = '0,
  parameter bit                CLEAR_DATA = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_register_if.slave  in_if,
  pipe_stage_register_if.master out_if,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic accept;
  logic consume;

  assign accept  = in_if.valid & ~skid_valid_q;
  assign consume = main_valid_q & out_if.ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    stall_d      = stall_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_DATA) begin
        main_data_d = CLR_VALUE;
        skid_data_d = CLR_VALUE;
      end
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else begin
      // Skid always drains first so ordering stays strictly FIFO.
      if (!main_valid_q || consume) begin
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_data_d  = in_if.data;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_data_d  = in_if.data;
        skid_valid_d = 1'b1;
      end

      if (main_valid_q && !out_if.ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= CLR_VALUE;
      skid_data_q  <= CLR_VALUE;
      stall_q      <= '0;
      flush_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      stall_q      <= stall_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign in_if.ready  = ~skid_valid_q;
  assign out_if.valid = main_valid_q;
  assign out_if.data  = main_data_q;
  assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;

endmodule
